// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one full-adder cell and a carry flop, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shs_q, shs_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, c, last;
  logic [WIDTH:0]   shs_ext;
  always_comb begin
    s       = sha_q[0] ^ shb_q[0] ^ carry_q;
    c       = (sha_q[0] & shb_q[0]) | ((sha_q[0] ^ shb_q[0]) & carry_q);
    shs_ext = {s, shs_q};
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == ADD) begin
      sha_d   = sha_q >> 1;
      shb_d   = shb_q >> 1;
      shs_d   = shs_ext[WIDTH:1];
      carry_d = c;
      cnt_d   = cnt_q + CW'(1);
      sum_d   = last ? shs_ext[WIDTH:1] : sum_q;
      cout_d  = last ? c : cout_q;
      state_d = last ? DONE : ADD;
    end else if (bus.start) begin
      sha_d   = bus.a;
      shb_d   = bus.b;
      carry_d = bus.cin;
      shs_d   = '0;
      cnt_d   = '0;
      state_d = ADD;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign bus.busy = state_q == ADD;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random scoreboard checks of the serial adder at WIDTH 1, 8 and 16
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(1))  bus1 ();
  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();
  serial_adder_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sb1[$], sb8[$], sb16[$];
  logic [63:0] prev8 = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst && bus1.done) begin
    if (sb1.size() == 0) check("w1_unexpected_done", 64'(bus1.done), 64'd0);
    else check("w1_result", 64'({bus1.cout, bus1.sum}), sb1.pop_front());
  end
  always @(negedge clk) if (!rst && bus8.done) begin
    if (sb8.size() == 0) check("w8_unexpected_done", 64'(bus8.done), 64'd0);
    else check("w8_result", 64'({bus8.cout, bus8.sum}), sb8.pop_front());
  end
  always @(negedge clk) if (!rst && bus16.done) begin
    if (sb16.size() == 0) check("w16_unexpected_done", 64'(bus16.done), 64'd0);
    else check("w16_result", 64'({bus16.cout, bus16.sum}), sb16.pop_front());
  end
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    sb8.push_back(64'(a) + 64'(b) + 64'(cin));
  endtask
  // issue from IDLE and check the exact 8-cycle busy window, held result and done pulse
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    drive8(a, b, cin);
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("busy_window", 64'(bus8.busy), 64'd1);
      check("sum_held", 64'({bus8.cout, bus8.sum}), prev8);
    end
    @(negedge clk);
    check("done_pulse", 64'({bus8.done, bus8.busy}), 64'b10);
    prev8 = 64'(a) + 64'(b) + 64'(cin);
    @(negedge clk);
    check("done_one_cycle", 64'({bus8.done, bus8.busy}), 64'b00);
  endtask
  initial begin
    bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
    bus8.start = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0;
    bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_sum", 64'(bus8.sum), 64'd0);
    check("rst_cout", 64'(bus8.cout), 64'd0);
    run_op8(8'h5A, 8'h33, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1);
    // a start during busy must be ignored
    @(negedge clk);
    drive8(8'h10, 8'h20, 1'b0);
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (5) @(negedge clk);
    check("ignored_start_done", 64'(bus8.done), 64'd1);
    check("ignored_start_sum", 64'({bus8.cout, bus8.sum}), 64'h030);
    @(negedge clk);
    check("ignored_start_idle", 64'({bus8.done, bus8.busy}), 64'b00);
    prev8 = 64'h030;
    // reset mid-operation abandons the op
    @(negedge clk);
    drive8(8'hAA, 8'h55, 1'b1);
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb8.delete();
    check("midrst_busy", 64'(bus8.busy), 64'd0);
    check("midrst_done", 64'(bus8.done), 64'd0);
    check("midrst_sum", 64'({bus8.cout, bus8.sum}), 64'd0);
    repeat (12) begin
      @(negedge clk);
      check("midrst_no_done", 64'(bus8.done), 64'd0);
    end
    prev8 = '0;
    run_op8(8'h7F, 8'h80, 1'b1);
    // start held high: back-to-back ops every 9 cycles
    @(negedge clk);
    drive8(8'h11, 8'h22, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) drive8(8'(8'hC3 + 8'(k * 37)), 8'(8'h5D + 8'(k * 91)), k[0]);
      else bus8.start = 1'b0;
      repeat (8) begin
        @(negedge clk);
        check("b2b_busy", 64'(bus8.busy), 64'd1);
      end
      @(negedge clk);
      check("b2b_done", 64'({bus8.done, bus8.busy}), 64'b10);
    end
    @(negedge clk);
    fork
      for (int i = 0; i < 1000; i++) begin
        bus1.start = 1'b1; bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
        sb1.push_back(64'(bus1.a) + 64'(bus1.b) + 64'(bus1.cin));
        @(posedge clk);
        #1 bus1.start = 1'b0;
        begin
          int t;
          t = 0;
          do begin @(negedge clk); t++; end while (!bus1.done && t < 6);
          if (!bus1.done) check("w1_timeout", 64'(bus1.done), 64'd1);
        end
        if ($urandom_range(1) == 0) @(negedge clk);
      end
      for (int i = 0; i < 1000; i++) begin
        bus8.start = 1'b1; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        sb8.push_back(64'(bus8.a) + 64'(bus8.b) + 64'(bus8.cin));
        @(posedge clk);
        #1 bus8.start = 1'b0;
        begin
          int t;
          t = 0;
          do begin @(negedge clk); t++; end while (!bus8.done && t < 13);
          if (!bus8.done) check("w8_timeout", 64'(bus8.done), 64'd1);
        end
        if ($urandom_range(1) == 0) @(negedge clk);
      end
      for (int i = 0; i < 1000; i++) begin
        bus16.start = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
        sb16.push_back(64'(bus16.a) + 64'(bus16.b) + 64'(bus16.cin));
        @(posedge clk);
        #1 bus16.start = 1'b0;
        begin
          int t;
          t = 0;
          do begin @(negedge clk); t++; end while (!bus16.done && t < 21);
          if (!bus16.done) check("w16_timeout", 64'(bus16.done), 64'd1);
        end
        if ($urandom_range(1) == 0) @(negedge clk);
      end
    join
    repeat (3) @(negedge clk);
    check("w1_sb_drained", 64'(sb1.size()), 64'd0);
    check("w8_sb_drained", 64'(sb8.size()), 64'd0);
    check("w16_sb_drained", 64'(sb16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
